// File: rtl/par_checking_sink.sv
// par_checking_sink: NoC local-port receiver with LFSR busy gate, destination and sequence checks.
// Define CHK_SINK_SEQ_EN to build the per-source sequence table and enable seq_err.
module par_checking_sink #(
    parameter int NODE_ID   = 0,
    parameter int HOSP      = 255,
    parameter int SEQ_W     = 8,
    parameter int ADDR_SZ   = 4,
    parameter int PL_SZ     = 16,
    parameter int HDR_SZ    = 2,
    parameter int NUM_NODES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   data,
    input  logic                              valid,
    output logic                              busy,
    output logic [19:0]                       rx_count,
    output logic [15:0]                       err_count,
    output logic                              dest_err,
    output logic                              seq_err,
    output logic [ADDR_SZ-1:0]                last_src
);

    localparam int DW     = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam int SRC_LO = ADDR_SZ;
    localparam int SEQ_LO = 2 * ADDR_SZ;
    localparam logic [7:0] SEED_RAW = 8'hA5 ^ NODE_ID[7:0];
    localparam logic [7:0] SEED     = (SEED_RAW == 8'h00) ? 8'h01 : SEED_RAW;
    localparam logic [7:0] HOSP_V   = HOSP[7:0];
    localparam logic [ADDR_SZ-1:0] MY_ADDR = NODE_ID[ADDR_SZ-1:0];

    logic [7:0]         lfsr_q, lfsr_d;
    logic               busy_q, busy_d;
    logic               xfer;
    logic               cap_valid_q;
    logic [ADDR_SZ-1:0] cap_dest_q, cap_src_q;
    logic [19:0]        rx_q, rx_d;
    logic [15:0]        err_q, err_d;
    logic               dest_err_q, dest_err_d;
    logic               seq_err_q, seq_err_d;
    logic [ADDR_SZ-1:0] last_src_q, last_src_d;
    logic               dest_bad, seq_bad;

    assign xfer = valid && !busy_q;

`ifdef CHK_SINK_SEQ_EN
    logic [DW-SEQ_LO-SEQ_W-1:0] unused_bits;
    logic [SEQ_W-1:0]           cap_seq_q;
    logic [SEQ_W-1:0]           exp_seq_q [NUM_NODES];
    logic [SEQ_W-1:0]           exp_rd;
    logic                       src_ok;

    assign unused_bits = data[DW-1:SEQ_LO+SEQ_W];
    assign src_ok      = int'(cap_src_q) < NUM_NODES;

    // Table is read, compared and written in the same cycle so back-to-back
    // flits from one source always see the freshly incremented value.
    always_comb begin
        exp_rd = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (int'(cap_src_q) == i) exp_rd = exp_seq_q[i];
        end
    end

    assign seq_bad = !src_ok || (cap_seq_q != exp_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_seq_q <= '0;
            for (int i = 0; i < NUM_NODES; i++) exp_seq_q[i] <= '0;
        end else begin
            if (xfer) cap_seq_q <= data[SEQ_LO+SEQ_W-1:SEQ_LO];
            // Match or mismatch, the next expected value is received seq + 1.
            if (cap_valid_q && src_ok) begin
                for (int i = 0; i < NUM_NODES; i++) begin
                    if (int'(cap_src_q) == i) exp_seq_q[i] <= cap_seq_q + SEQ_W'(1);
                end
            end
        end
    end
`else
    logic [DW-SEQ_LO-1:0] unused_bits;
    assign unused_bits = data[DW-1:SEQ_LO];
    assign seq_bad     = 1'b0;
`endif

    always_comb begin
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        busy_d     = (lfsr_d > HOSP_V);
        dest_bad   = (cap_dest_q != MY_ADDR);
        rx_d       = rx_q;
        err_d      = err_q;
        dest_err_d = dest_err_q;
        seq_err_d  = seq_err_q;
        last_src_d = last_src_q;
        if (cap_valid_q) begin
            if (rx_q != '1) rx_d = rx_q + 20'd1;
            if ((dest_bad || seq_bad) && (err_q != '1)) err_d = err_q + 16'd1;
            dest_err_d = dest_err_q | dest_bad;
            seq_err_d  = seq_err_q | seq_bad;
            last_src_d = cap_src_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q      <= SEED;
            busy_q      <= 1'b1;
            cap_valid_q <= 1'b0;
            cap_dest_q  <= '0;
            cap_src_q   <= '0;
            rx_q        <= '0;
            err_q       <= '0;
            dest_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            last_src_q  <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            busy_q      <= busy_d;
            cap_valid_q <= xfer;
            if (xfer) begin
                cap_dest_q <= data[ADDR_SZ-1:0];
                cap_src_q  <= data[SRC_LO+ADDR_SZ-1:SRC_LO];
            end
            rx_q       <= rx_d;
            err_q      <= err_d;
            dest_err_q <= dest_err_d;
            seq_err_q  <= seq_err_d;
            last_src_q <= last_src_d;
        end
    end

    assign busy      = busy_q;
    assign rx_count  = rx_q;
    assign err_count = err_q;
    assign dest_err  = dest_err_q;
    assign seq_err   = seq_err_q;
    assign last_src  = last_src_q;

endmodule
